// File: rtl/error_metric_accum.sv
// error_metric_accum
// Streaming error-metric engine for characterising approximate arithmetic.
// Consumes (approximate, exact) pairs over a valid/ready stream and keeps the
// sum of absolute error, sample count, erroneous-sample count, maximum exact
// magnitude and maximum absolute error. Two pipeline stages feed a saturating
// result stage; results are held from the o_done pulse until the next start.
module error_metric_accum #(
    parameter int W      = 16,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 48
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_approx,
    input  logic [W-1:0]     i_exact,
    input  logic             i_last,
    output logic             o_busy,
    output logic             o_done,
    output logic [ACC_W-1:0] o_sum_abs_err,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [W-1:0]     o_max_exact,
    output logic [W:0]       o_max_abs_err,
    output logic             o_overflow
);

    // Adder wide enough for either operand plus a carry bit, so saturation
    // is detected even when |diff| is wider than the accumulator.
    localparam int SUM_W = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic   ready_reg, busy_reg, done_reg, done_next;
    logic   accept, clear;

    // Pipeline stage registers
    logic           s1_valid_reg, s2_valid_reg;
    logic [W:0]     s1_diff_reg;
    logic [W-1:0]   s1_mag_reg;
    logic [W:0]     s2_abs_reg;
    logic [W-1:0]   s2_mag_reg;
    logic           s2_nz_reg;

    // Result registers
    logic [ACC_W-1:0] sum_reg, sum_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] errc_reg, errc_next;
    logic [W-1:0]     maxe_reg, maxe_next;
    logic [W:0]       maxd_reg, maxd_next;
    logic             ovf_reg, ovf_next;
    logic [SUM_W-1:0] sum_wide;

    // Operand extension and exact magnitude
    logic [W:0]   approx_ext, exact_ext;
    logic [W-1:0] exact_mag;

    assign accept = i_valid && ready_reg;
    assign clear  = i_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    generate
        if (SIGNED != 0) begin : g_signed
            assign approx_ext = {i_approx[W-1], i_approx};
            assign exact_ext  = {i_exact[W-1], i_exact};
            // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits
            assign exact_mag  = i_exact[W-1] ? (~i_exact + {{(W-1){1'b0}}, 1'b1}) : i_exact;
        end else begin : g_unsigned
            assign approx_ext = {1'b0, i_approx};
            assign exact_ext  = {1'b0, i_exact};
            assign exact_mag  = i_exact;
        end
    endgenerate

    // Next-state logic for the run controller
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_start) state_next = ST_RUN;
            ST_RUN:   if (accept && i_last) state_next = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_reg && !s2_valid_reg) state_next = ST_DONE;
            ST_DONE:  if (i_start) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
        done_next = (state_reg == ST_DRAIN) && (state_next == ST_DONE);
    end

    // State register plus registered handshake/status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_RUN);
            busy_reg  <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            done_reg  <= done_next;
        end
    end

    // Stage 1: signed/unsigned difference and exact magnitude
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_diff_reg  <= '0;
            s1_mag_reg   <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_diff_reg <= approx_ext - exact_ext;
                s1_mag_reg  <= exact_mag;
            end
        end
    end

    // Stage 2: absolute error and nonzero flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_abs_reg   <= '0;
            s2_mag_reg   <= '0;
            s2_nz_reg    <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_abs_reg <= s1_diff_reg[W] ? (~s1_diff_reg + {{W{1'b0}}, 1'b1}) : s1_diff_reg;
                s2_mag_reg <= s1_mag_reg;
                s2_nz_reg  <= |s1_diff_reg;
            end
        end
    end

    // Saturating accumulate and strict-greater running maxima
    always_comb begin
        sum_next   = sum_reg;
        count_next = count_reg;
        errc_next  = errc_reg;
        maxe_next  = maxe_reg;
        maxd_next  = maxd_reg;
        ovf_next   = ovf_reg;
        sum_wide   = SUM_W'(sum_reg) + SUM_W'(s2_abs_reg);
        if (clear) begin
            sum_next   = '0;
            count_next = '0;
            errc_next  = '0;
            maxe_next  = '0;
            maxd_next  = '0;
            ovf_next   = 1'b0;
        end else if (s2_valid_reg) begin
            if (|sum_wide[SUM_W-1:ACC_W]) begin
                sum_next = '1;
                ovf_next = 1'b1;
            end else begin
                sum_next = sum_wide[ACC_W-1:0];
            end
            if (&count_reg) ovf_next = 1'b1;
            else            count_next = count_reg + CNT_W'(1);
            if (s2_nz_reg) begin
                if (&errc_reg) ovf_next = 1'b1;
                else           errc_next = errc_reg + CNT_W'(1);
            end
            if (s2_abs_reg > maxd_reg) maxd_next = s2_abs_reg;
            if (s2_mag_reg > maxe_reg) maxe_next = s2_mag_reg;
        end
    end

    // Result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_reg   <= '0;
            count_reg <= '0;
            errc_reg  <= '0;
            maxe_reg  <= '0;
            maxd_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            count_reg <= count_next;
            errc_reg  <= errc_next;
            maxe_reg  <= maxe_next;
            maxd_reg  <= maxd_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign o_ready       = ready_reg;
    assign o_busy        = busy_reg;
    assign o_done        = done_reg;
    assign o_sum_abs_err = sum_reg;
    assign o_count       = count_reg;
    assign o_err_count   = errc_reg;
    assign o_max_exact   = maxe_reg;
    assign o_max_abs_err = maxd_reg;
    assign o_overflow    = ovf_reg;

endmodule

// File: tb/tb_error_metric_accum.sv
// Bench for error_metric_accum: directed runs on a signed W=16 instance and a
// saturating W=8/ACC_W=8 unsigned instance. Expected results are queued when
// a run's last sample is accepted; a monitor pops and compares on o_done.
`timescale 1ns/1ps
module tb_error_metric_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance (W=16, SIGNED=1)
    logic        start, valid, last;
    logic [15:0] approx, exact;
    logic        ready, busy, done, ovf;
    logic [47:0] sum;
    logic [31:0] cnt, errc;
    logic [15:0] maxe;
    logic [16:0] maxd;

    // Saturation instance (W=8, SIGNED=0, ACC_W=8)
    logic        s_start, s_valid, s_last;
    logic [7:0]  s_approx, s_exact;
    logic        s_ready, s_busy, s_done, s_ovf;
    logic [7:0]  s_sum;
    logic [31:0] s_cnt, s_errc;
    logic [7:0]  s_maxe;
    logic [8:0]  s_maxd;

    error_metric_accum #(.W(16), .SIGNED(1), .CNT_W(32), .ACC_W(48)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
        .o_ready(ready), .i_approx(approx), .i_exact(exact), .i_last(last),
        .o_busy(busy), .o_done(done), .o_sum_abs_err(sum), .o_count(cnt),
        .o_err_count(errc), .o_max_exact(maxe), .o_max_abs_err(maxd),
        .o_overflow(ovf)
    );

    error_metric_accum #(.W(8), .SIGNED(0), .CNT_W(32), .ACC_W(8)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_valid(s_valid),
        .o_ready(s_ready), .i_approx(s_approx), .i_exact(s_exact), .i_last(s_last),
        .o_busy(s_busy), .o_done(s_done), .o_sum_abs_err(s_sum), .o_count(s_cnt),
        .o_err_count(s_errc), .o_max_exact(s_maxe), .o_max_abs_err(s_maxd),
        .o_overflow(s_ovf)
    );

    typedef struct {
        string       name;
        logic [63:0] sum;
        logic [63:0] cnt;
        logic [63:0] errc;
        logic [63:0] maxe;
        logic [63:0] maxd;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_sat[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic compare_result(input exp_t e, input logic [63:0] s, input logic [63:0] c,
                                  input logic [63:0] ec, input logic [63:0] me,
                                  input logic [63:0] md, input logic ov, input int cy);
        check({e.name, " sum"}, s, e.sum);
        check({e.name, " count"}, c, e.cnt);
        check({e.name, " err_count"}, ec, e.errc);
        check({e.name, " max_exact"}, me, e.maxe);
        check({e.name, " max_abs_err"}, md, e.maxd);
        check({e.name, " overflow"}, 64'(ov), 64'(e.ovf));
        check({e.name, " done_cycle"}, 64'(cy), 64'(e.done_cyc));
    endtask

    // Monitor: one comparison set per o_done pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (q_main.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done main: got done=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q_main.pop_front();
                compare_result(e, 64'(sum), 64'(cnt), 64'(errc), 64'(maxe), 64'(maxd), ovf, cyc);
                $display("run %s: sum=%0d count=%0d err=%0d max_exact=%0d max_abs_err=%0d ovf=%0d",
                         e.name, sum, cnt, errc, maxe, maxd, ovf);
            end
        end
        if (s_done === 1'b1) begin
            if (q_sat.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done sat: got done=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q_sat.pop_front();
                compare_result(e, 64'(s_sum), 64'(s_cnt), 64'(s_errc), 64'(s_maxe), 64'(s_maxd), s_ovf, cyc);
                $display("run %s: sum=%0d count=%0d err=%0d max_exact=%0d max_abs_err=%0d ovf=%0d",
                         e.name, s_sum, s_cnt, s_errc, s_maxe, s_maxd, s_ovf);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit to_sat, input string name, input logic [63:0] s_v,
                        input logic [63:0] c_v, input logic [63:0] ec_v, input logic [63:0] me_v,
                        input logic [63:0] md_v, input logic ov_v, input int dc);
        exp_t e;
        e.name = name; e.sum = s_v; e.cnt = c_v; e.errc = ec_v;
        e.maxe = me_v; e.maxd = md_v; e.ovf = ov_v; e.done_cyc = dc;
        if (to_sat) q_sat.push_back(e);
        else        q_main.push_back(e);
    endtask

    task automatic send_m(input logic [15:0] a, input logic [15:0] e, input logic l, output int acc_cyc);
        int   guard;
        logic took;
        guard = 0;
        valid = 1'b1; approx = a; exact = e; last = l;
        do begin
            took = ready;
            tick(1);
            guard++;
        end while (!took && guard < 50);
        if (!took) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout main: got ready=0 expected 1");
        end
        acc_cyc = cyc;
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] a, input logic [7:0] e, input logic l, output int acc_cyc);
        int   guard;
        logic took;
        guard = 0;
        s_valid = 1'b1; s_approx = a; s_exact = e; s_last = l;
        do begin
            took = s_ready;
            tick(1);
            guard++;
        end while (!took && guard < 50);
        if (!took) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout sat: got ready=0 expected 1");
        end
        acc_cyc = cyc;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic start_m();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic start_s();
        s_start = 1'b1; tick(1); s_start = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((q_main.size() != 0 || q_sat.size() != 0) && g < 40) begin
            tick(1);
            g++;
        end
        if (q_main.size() != 0 || q_sat.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got %0d pending results expected 0", q_main.size() + q_sat.size());
            q_main.delete();
            q_sat.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 64'(ready), 0);
        check({tag, " busy"}, 64'(busy), 0);
        check({tag, " done"}, 64'(done), 0);
        check({tag, " sum"}, 64'(sum), 0);
        check({tag, " count"}, 64'(cnt), 0);
        check({tag, " err_count"}, 64'(errc), 0);
        check({tag, " max_exact"}, 64'(maxe), 0);
        check({tag, " max_abs_err"}, 64'(maxd), 0);
        check({tag, " overflow"}, 64'(ovf), 0);
        check({tag, " sat_ready"}, 64'(s_ready), 0);
        check({tag, " sat_busy"}, 64'(s_busy), 0);
        check({tag, " sat_sum"}, 64'(s_sum), 0);
        check({tag, " sat_count"}, 64'(s_cnt), 0);
        check({tag, " sat_overflow"}, 64'(s_ovf), 0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          ac;
        int          p, ap, d, ad, mg;
        logic [63:0] m_sum, m_err, m_maxe, m_maxd;
        real         nmed, erate;

        rst_n = 1'b0;
        start = 0; valid = 0; last = 0; approx = 0; exact = 0;
        s_start = 0; s_valid = 0; s_last = 0; s_approx = 0; s_exact = 0;

        // Reset held with random inputs toggling
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); valid = 1'($urandom); last = 1'($urandom);
            approx = 16'($urandom); exact = 16'($urandom);
            s_start = 1'($urandom); s_valid = 1'($urandom);
            s_approx = 8'($urandom); s_exact = 8'($urandom);
            tick(1);
            check_all_zero("reset_held");
        end
        start = 0; valid = 0; last = 0; s_start = 0; s_valid = 0; s_last = 0;
        #2 rst_n = 1'b1;
        tick(2);
        check_all_zero("reset_released");

        // Exact match run, also checks two-edge result latency
        start_m();
        check("busy_in_run", 64'(busy), 1);
        send_m(16'd10, 16'd10, 1'b0, ac);
        send_m(16'(-3), 16'(-3), 1'b0, ac);
        send_m(16'd200, 16'd200, 1'b0, ac);
        check("latency_count_after_k2", 64'(cnt), 1);
        send_m(16'(-7), 16'(-7), 1'b1, ac);
        push(1'b0, "exact_match", 0, 4, 0, 200, 0, 1'b0, ac + 3);
        wait_drain();

        // Signed extremes
        start_m();
        send_m(16'(-5), 16'd3, 1'b0, ac);
        send_m(16'd32767, 16'h8000, 1'b0, ac);
        send_m(16'd0, 16'd0, 1'b1, ac);
        push(1'b0, "signed_extremes", 65543, 3, 2, 32768, 65535, 1'b0, ac + 3);
        wait_drain();

        // Handshake: random bubbles, traffic and a start pulse during DRAIN/DONE
        start_m();
        send_m(16'd100, 16'd90, 1'b0, ac);
        tick($urandom_range(0, 3));
        send_m(16'(-50), 16'(-60), 1'b0, ac);
        tick($urandom_range(0, 3));
        send_m(16'd7, 16'd7, 1'b0, ac);
        tick($urandom_range(0, 3));
        send_m(16'd0, 16'(-1000), 1'b1, ac);
        check("ready_after_last", 64'(ready), 0);
        push(1'b0, "handshake", 1020, 4, 3, 1000, 1000, 1'b0, ac + 3);
        valid = 1'b1; approx = 16'd5; exact = 16'd99; last = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("ready_low_drain_done", 64'(ready), 0);
            tick(1);
        end
        valid = 1'b0; last = 1'b0;
        wait_drain();
        check("held_count_in_done", 64'(cnt), 4);

        // Restart from DONE clears results
        start_m();
        check("restart_cleared_count", 64'(cnt), 0);
        check("restart_cleared_sum", 64'(sum), 0);
        check("restart_busy", 64'(busy), 1);
        send_m(16'd3, 16'd1, 1'b0, ac);
        send_m(16'(-2), 16'd2, 1'b1, ac);
        push(1'b0, "restart", 6, 2, 2, 2, 4, 1'b0, ac + 3);
        wait_drain();

        // Saturation on the narrow unsigned instance
        start_s();
        send_s(8'd200, 8'd0, 1'b0, ac);
        send_s(8'd100, 8'd0, 1'b1, ac);
        push(1'b1, "saturation", 255, 2, 2, 0, 200, 1'b1, ac + 3);
        wait_drain();
        tick(2);
        check("overflow_held_done", 64'(s_ovf), 1);
        start_s();
        check("overflow_cleared_start", 64'(s_ovf), 0);
        send_s(8'd5, 8'd3, 1'b1, ac);
        push(1'b1, "after_saturation", 2, 1, 1, 3, 2, 1'b0, ac + 3);
        wait_drain();

        // Aborted sweep: asynchronous reset mid-run, checked before any edge
        start_m();
        for (int i = 0; i < 300; i++) send_m(16'(i * 3), 16'(i), 1'b0, ac);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset_midrun");
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);

        // Full sweep: exact 8x8 signed product vs product truncated in low 4 bits
        m_sum = 0; m_err = 0; m_maxe = 0; m_maxd = 0;
        start_m();
        for (int a = -128; a < 128; a++) begin
            for (int b = -128; b < 128; b++) begin
                p  = a * b;
                ap = p & ~15;
                d  = ap - p;
                ad = (d < 0) ? -d : d;
                mg = (p < 0) ? -p : p;
                m_sum = m_sum + 64'(ad);
                if (d != 0) m_err = m_err + 1;
                if (64'(ad) > m_maxd) m_maxd = 64'(ad);
                if (64'(mg) > m_maxe) m_maxe = 64'(mg);
                send_m(16'(ap), 16'(p), (a == 127 && b == 127), ac);
            end
        end
        push(1'b0, "sweep", m_sum, 65536, m_err, m_maxe, m_maxd, 1'b0, ac + 3);
        wait_drain();
        check("sweep_max_exact_hand", 64'(maxe), 16384);
        check("sweep_max_abs_err_hand", 64'(maxd), 15);
        if (cnt != 0 && maxe != 0) begin
            nmed  = real'(sum) / (real'(cnt) * real'(maxe));
            erate = real'(errc) / real'(cnt);
            $display("sweep metrics: NMED=%e error_rate=%f", nmed, erate);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/error_metric_accum.md
Name: error_metric_accum

Overview:
- Synthesizable streaming error-metric engine for approximate-arithmetic characterisation.
- Accepts paired (approximate, exact) results over a valid/ready stream and accumulates:
  - sum of absolute error
  - sample count
  - maximum exact magnitude
  - maximum absolute error
  - count of erroneous samples
- Host or bench derives NMED = sum/(count*max_exact) and error rate = err_count/count from the held results.
- Sits beside exact/approximate multiplier pairs in characterisation and in-system self-test builds.

Parameters:
- W, 16, width of approximate and exact operands (two's complement when SIGNED=1).
- SIGNED, 1, 1 = operands signed, 0 = operands unsigned.
- CNT_W, 32, width of sample and error counters.
- ACC_W, 48, width of the absolute-error accumulator.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  single-cycle pulse; clears results and begins a run (IDLE/DONE only).
- i_valid  in  1  input sample valid.
- o_ready  out  1  block accepts a sample this cycle.
- i_approx  in  W  approximate result.
- i_exact  in  W  exact result.
- i_last  in  1  qualifies the final sample of a run (sampled with i_valid&&o_ready).
- o_busy  out  1  high in RUN and DRAIN.
- o_done  out  1  one-cycle pulse when results are final.
- o_sum_abs_err  out  ACC_W  sum of |approx-exact|.
- o_count  out  CNT_W  samples accepted.
- o_err_count  out  CNT_W  samples with approx != exact.
- o_max_exact  out  W  max |exact| (SIGNED=1) or max exact (SIGNED=0), unsigned, floor 0.
- o_max_abs_err  out  W+1  max |approx-exact|, unsigned.
- o_overflow  out  1  sticky; accumulator or counter saturated this run.

Behaviour:
- Reset (i_rst_n=0, async): state IDLE; all outputs 0, including o_ready, o_busy and o_done; pipeline valid bits cleared. Reset mid-run discards everything.
- Accept = i_valid && o_ready. o_ready = 1 only in RUN and is a registered, state-derived signal that never depends on i_valid in the same cycle.
- FSM states:
  - IDLE: i_start -> RUN; all result registers cleared on that edge.
  - RUN: accept with i_last=1 -> DRAIN; o_ready falls the next cycle.
  - DRAIN: o_ready=0; when both pipeline stages are empty -> DONE, and o_done=1 for exactly that first DONE cycle.
  - DONE: results held stable; i_start -> RUN (clear + restart).
- i_start is ignored in RUN and DRAIN.
- i_last without accept is ignored. A run has at least one sample; there is no empty-run exit.
- Pipeline stage 1 (register): diff = approx - exact computed at W+1 bits with sign/zero extension per SIGNED; mag_exact = |exact| (SIGNED) or exact.
- Pipeline stage 2 (register): |diff| (W+1 bit unsigned) is added into the accumulator. Also updated in stage 2: count+1, err_count+1 if diff!=0, max_abs_err, max_exact.
- Latency: sample accepted at edge k is visible in all outputs after edge k+2.
- o_done asserts in the cycle after the last sample's stage-2 update; for a last accept at edge k, o_done is high in the cycle following edge k+3.
- Full throughput: one sample per cycle; bubbles (i_valid=0) insert no-ops.
- Saturation: o_sum_abs_err, o_count and o_err_count clamp at all-ones and never wrap. Any clamp sets o_overflow, which stays high until the next i_start or reset.
- Extremes (W=16, SIGNED=1): approx=32767, exact=-32768 -> |diff|=65535; |exact| of -32768 = 32768 fits the W-bit unsigned o_max_exact.
- Equal values never update the running max registers; updates use strict greater-than only.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> every output 0. Release; outputs remain 0 and state is IDLE (o_ready=0).
- Exact match: start, then 4 samples (approx=exact = 10,-3,200,-7), last on the 4th -> o_done pulse 3 cycles after the last accept. Results: sum=0, count=4, err_count=0, max_exact=200, max_abs_err=0, overflow=0.
- Signed extremes: samples (-5,3), (32767,-32768), (0,0) -> sum=65543, err_count=2, max_abs_err=65535, max_exact=32768, count=3.
- Handshake: random i_valid gaps in RUN; assert i_valid during DRAIN and DONE -> those samples are not counted, and o_ready=0 from the cycle after the last accept. A second i_start in DONE clears results and runs a fresh 2-sample run correctly.
- Saturation with ACC_W=8, SIGNED=0, W=8: samples (200,0) then (100,0) -> o_sum_abs_err=255 and o_overflow=1. Overflow stays 1 to DONE and clears on the next i_start.
- Full sweep W=16 products of all 8x8 signed operand pairs, using the exact multiplier against an approximate multiplier -> count=65536. sum/err_count/max values must match the bench reference model bit-exactly, and NMED is computed from the outputs. Apply an async reset mid-sweep, then restart -> clean results.
